// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a cons-cell memory; read done 6 edges, write done 5 edges after request.
// No backpressure: requesters hold req until their one-cycle done; a watchdog aborts a memory that never answers.
module mem_arbiter #(
  parameter int          WatchdogCycles = 16,
  parameter logic [15:0] NilPtr         = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [15:0] p0_addr,
  input  logic [14:0] p0_type,
  input  logic [15:0] p0_car,
  input  logic [15:0] p0_cdr,
  output logic        p0_done,
  output logic [14:0] p0_header,
  output logic [15:0] p0_car_out,
  output logic [15:0] p0_cdr_out,
  output logic [15:0] p0_ptr,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [15:0] p1_addr,
  input  logic [14:0] p1_type,
  input  logic [15:0] p1_car,
  input  logic [15:0] p1_cdr,
  output logic        p1_done,
  output logic [14:0] p1_header,
  output logic [15:0] p1_car_out,
  output logic [15:0] p1_cdr_out,
  output logic [15:0] p1_ptr,
  output logic        p1_err,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [15:0] mem_addr,
  output logic [14:0] mem_type,
  output logic [15:0] mem_car,
  output logic [15:0] mem_cdr,
  input  logic [14:0] mem_header,
  input  logic [15:0] mem_car_out,
  input  logic [15:0] mem_cdr_out,
  input  logic [15:0] mem_ptr,
  input  logic        mem_done,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int WdW = $clog2(WatchdogCycles + 1);

  state_t       state;
  logic         last_grant;
  logic         cmd_id;
  logic         cmd_we;
  logic [15:0]  cmd_addr;
  logic [14:0]  cmd_type;
  logic [15:0]  cmd_car;
  logic [15:0]  cmd_cdr;
  logic [WdW-1:0] wd_cnt;
  logic         grant_id;
  logic         driving;

  // A tie goes to the port that did not win last time.
  always_comb begin
    grant_id = p1_req;
    if (p0_req && p1_req) grant_id = ~last_grant;
  end

  assign driving  = (state == ISSUE) || (state == WAIT);
  assign mem_addr = driving ? cmd_addr : '0;
  assign mem_type = driving ? cmd_type : '0;
  assign mem_car  = driving ? cmd_car  : '0;
  assign mem_cdr  = driving ? cmd_cdr  : '0;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      cmd_id           <= 1'b0;
      cmd_we           <= 1'b0;
      cmd_addr         <= '0;
      cmd_type         <= '0;
      cmd_car          <= '0;
      cmd_cdr          <= '0;
      wd_cnt           <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      timeout          <= 1'b0;
      p0_done          <= 1'b0;
      p0_err           <= 1'b0;
      p0_header        <= '0;
      p0_car_out       <= '0;
      p0_cdr_out       <= '0;
      p0_ptr           <= '0;
      p1_done          <= 1'b0;
      p1_err           <= 1'b0;
      p1_header        <= '0;
      p1_car_out       <= '0;
      p1_cdr_out       <= '0;
      p1_ptr           <= '0;
    end else begin
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      p0_done          <= 1'b0;
      p0_err           <= 1'b0;
      p1_done          <= 1'b0;
      p1_err           <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            cmd_id           <= grant_id;
            last_grant       <= grant_id;
            cmd_we           <= grant_id ? p1_we   : p0_we;
            cmd_addr         <= grant_id ? p1_addr : p0_addr;
            cmd_type         <= grant_id ? p1_type : p0_type;
            cmd_car          <= grant_id ? p1_car  : p0_car;
            cmd_cdr          <= grant_id ? p1_cdr  : p0_cdr;
            mem_read_enable  <= grant_id ? !p1_we  : !p0_we;
            mem_write_enable <= grant_id ? p1_we   : p0_we;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (mem_done) begin
            state <= RESP;
            if (!cmd_id) begin
              p0_done <= 1'b1;
              if (cmd_we) p0_ptr <= mem_ptr;
              else begin
                p0_header  <= mem_header;
                p0_car_out <= mem_car_out;
                p0_cdr_out <= mem_cdr_out;
              end
            end else begin
              p1_done <= 1'b1;
              if (cmd_we) p1_ptr <= mem_ptr;
              else begin
                p1_header  <= mem_header;
                p1_car_out <= mem_car_out;
                p1_cdr_out <= mem_cdr_out;
              end
            end
          end else if (wd_cnt == WdW'(WatchdogCycles - 1)) begin
            // Abort: read results are left as they were, a write reports the nil pointer.
            state   <= RESP;
            timeout <= 1'b1;
            if (!cmd_id) begin
              p0_done <= 1'b1;
              p0_err  <= 1'b1;
              if (cmd_we) p0_ptr <= NilPtr;
            end else begin
              p1_done <= 1'b1;
              p1_err  <= 1'b1;
              if (cmd_we) p1_ptr <= NilPtr;
            end
          end else begin
            wd_cnt <= wd_cnt + WdW'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural cons-cell memory (read answers in 4 edges, write in 3).
// The memory can be stalled to exercise the watchdog and can emit stray done pulses.
module tb_mem_arbiter;

  localparam logic [14:0] TYPE_NUMBER = 15'd2;
  localparam logic [15:0] NIL         = 16'h0000;
  localparam logic [15:0] NIL_PTR     = 16'hDEAD;

  logic        clk, rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_car, p0_cdr, p1_addr, p1_car, p1_cdr;
  logic [14:0] p0_type, p1_type;
  logic        p0_done, p0_err, p1_done, p1_err;
  logic [14:0] p0_header, p1_header;
  logic [15:0] p0_car_out, p0_cdr_out, p0_ptr, p1_car_out, p1_cdr_out, p1_ptr;
  logic        mem_read_enable, mem_write_enable, mem_done, busy, timeout;
  logic [15:0] mem_addr, mem_car, mem_cdr, mem_car_out, mem_cdr_out, mem_ptr;
  logic [14:0] mem_type, mem_header;

  logic        stall, spur;
  logic [2:0]  m_cnt;
  logic        m_rd;
  logic [15:0] m_addr, heap;
  int          n_checks, n_pass, cnt0, cnt1;

  mem_arbiter #(.WatchdogCycles(16), .NilPtr(NIL_PTR)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_type(p0_type),
    .p0_car(p0_car), .p0_cdr(p0_cdr), .p0_done(p0_done), .p0_header(p0_header),
    .p0_car_out(p0_car_out), .p0_cdr_out(p0_cdr_out), .p0_ptr(p0_ptr), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_type(p1_type),
    .p1_car(p1_car), .p1_cdr(p1_cdr), .p1_done(p1_done), .p1_header(p1_header),
    .p1_car_out(p1_car_out), .p1_cdr_out(p1_cdr_out), .p1_ptr(p1_ptr), .p1_err(p1_err),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_addr(mem_addr), .mem_type(mem_type), .mem_car(mem_car), .mem_cdr(mem_cdr),
    .mem_header(mem_header), .mem_car_out(mem_car_out), .mem_cdr_out(mem_cdr_out),
    .mem_ptr(mem_ptr), .mem_done(mem_done), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: cell 3 holds a number 0x789A, other cells hold values derived from the address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 3'd0; m_rd <= 1'b0; m_addr <= 16'h0; heap <= 16'h0004;
      mem_done <= 1'b0; mem_header <= '0; mem_car_out <= '0; mem_cdr_out <= '0; mem_ptr <= '0;
    end else begin
      mem_done <= spur;
      if (mem_read_enable) begin
        m_cnt <= 3'd3; m_rd <= 1'b1; m_addr <= mem_addr;
      end else if (mem_write_enable) begin
        m_cnt <= 3'd2; m_rd <= 1'b0;
      end else if (m_cnt != 3'd0) begin
        m_cnt <= m_cnt - 3'd1;
        if (m_cnt == 3'd1 && !stall) begin
          mem_done <= 1'b1;
          if (m_rd) begin
            if (m_addr == 16'h0003) begin
              mem_header <= TYPE_NUMBER; mem_car_out <= 16'h789A; mem_cdr_out <= NIL;
            end else begin
              mem_header  <= {7'd0, m_addr[7:0]};
              mem_car_out <= m_addr + 16'h1000;
              mem_cdr_out <= m_addr + 16'h2000;
            end
          end else begin
            mem_ptr <= heap + 16'h0002;
            heap    <= heap + 16'h0004;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (p0_done) cnt0++;
    if (p1_done) cnt1++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_type = 0; p0_car = 0; p0_cdr = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_type = 0; p1_car = 0; p1_cdr = 0;
    stall = 0; spur = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    int c0, c1;
    rst_n = 1'b0;
    p0_req = 1'b1;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0)
      $display("FAIL reset_enables: got %b%b want 00", mem_read_enable, mem_write_enable); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else n_pass++;
    n_checks++; if ({p0_done, p1_done, p0_err, p1_err} !== 4'b0)
      $display("FAIL reset_done_err: got %b want 0000", {p0_done, p1_done, p0_err, p1_err}); else n_pass++;
    n_checks++; if (p0_ptr !== 16'h0 || p1_car_out !== 16'h0 || p0_header !== 15'h0)
      $display("FAIL reset_results: got %h %h %h want 0 0 0", p0_ptr, p1_car_out, p0_header); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0) $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); else n_pass++;
    p0_req = 1'b0;
    do_reset();
    c0 = cnt0; c1 = cnt1;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0 || cnt0 != c0 || cnt1 != c1)
      $display("FAIL stray_mem_done: busy %b dones %0d/%0d want busy 0 and no dones", busy, cnt0 - c0, cnt1 - c1); else n_pass++;
  endtask

  task automatic test_read();
    int c1;
    do_reset();
    c1 = cnt1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0003;
    tick();
    n_checks++; if (mem_read_enable !== 1'b1 || mem_write_enable !== 1'b0 || mem_addr !== 16'h0003)
      $display("FAIL read_issue: got re %b we %b addr %h want 1 0 0003", mem_read_enable, mem_write_enable, mem_addr); else n_pass++;
    tick();
    n_checks++; if (mem_read_enable !== 1'b0 || busy !== 1'b1)
      $display("FAIL read_enable_pulse: got re %b busy %b want 0 1", mem_read_enable, busy); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if (p0_done !== 1'b0) $display("FAIL read_early_done: got %b want 0 after edge 5", p0_done); else n_pass++;
    tick();
    n_checks++; if (p0_done !== 1'b1 || p0_err !== 1'b0)
      $display("FAIL read_done: got done %b err %b want 1 0 after edge 6", p0_done, p0_err); else n_pass++;
    n_checks++; if (p0_header !== TYPE_NUMBER || p0_car_out !== 16'h789A || p0_cdr_out !== NIL)
      $display("FAIL read_data: got %h %h %h want %h 789a 0000", p0_header, p0_car_out, p0_cdr_out, TYPE_NUMBER); else n_pass++;
    p0_req = 1'b0;
    tick();
    n_checks++; if (p0_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL read_done_pulse: got done %b busy %b want 0 0", p0_done, busy); else n_pass++;
    tick();
    n_checks++; if (cnt1 != c1 || p0_ptr !== 16'h0)
      $display("FAIL read_side_effects: p1 dones %0d p0_ptr %h want 0 0000", cnt1 - c1, p0_ptr); else n_pass++;
  endtask

  task automatic test_write();
    int c0;
    do_reset();
    c0 = cnt0;
    p1_req = 1'b1; p1_we = 1'b1; p1_type = TYPE_NUMBER; p1_car = 16'h1234; p1_cdr = NIL;
    tick();
    n_checks++; if (mem_write_enable !== 1'b1 || mem_read_enable !== 1'b0 || mem_type !== TYPE_NUMBER || mem_car !== 16'h1234)
      $display("FAIL write_issue: got we %b re %b type %h car %h want 1 0 %h 1234", mem_write_enable, mem_read_enable, mem_type, mem_car, TYPE_NUMBER); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if (p1_done !== 1'b0) $display("FAIL write_early_done: got %b want 0 after edge 4", p1_done); else n_pass++;
    tick();
    n_checks++; if (p1_done !== 1'b1 || p1_err !== 1'b0 || p1_ptr !== 16'h0006)
      $display("FAIL write_done: got done %b err %b ptr %h want 1 0 0006", p1_done, p1_err, p1_ptr); else n_pass++;
    n_checks++; if (p1_header !== 15'h0 || p1_car_out !== 16'h0)
      $display("FAIL write_read_results: got %h %h want 0 0", p1_header, p1_car_out); else n_pass++;
    p1_req = 1'b0;
    tick(); tick();
    n_checks++; if (cnt0 != c0 || busy !== 1'b0)
      $display("FAIL write_side_effects: p0 dones %0d busy %b want 0 0", cnt0 - c0, busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    int n;
    logic [3:0] order;
    logic [3:0] exp_order;
    do_reset();
    exp_order = 4'b1010;
    order = 4'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0003;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0005;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(p0_done || p1_done) && n < 20) begin tick(); n++; end
      n_checks++;
      if (n >= 20) $display("FAIL rr_wait_%0d: no done within 20 cycles, required one", i);
      else begin
        n_pass++;
        order[i] = p1_done;
      end
      if (i == 3) begin p0_req = 1'b0; p1_req = 1'b0; end
      tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL rr_idle_gap_%0d: busy %b want 0", i, busy); else n_pass++;
    end
    n_checks++; if (order !== exp_order) $display("FAIL rr_order: got %b want %b (bit i = port of grant i)", order, exp_order); else n_pass++;
    n_checks++; if (p1_header !== 15'h0005 || p1_car_out !== 16'h1005 || p0_car_out !== 16'h789A)
      $display("FAIL rr_data: got %h %h %h want 0005 1005 789a", p1_header, p1_car_out, p0_car_out); else n_pass++;
  endtask

  task automatic test_addr_stable();
    do_reset();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0003;
    tick(); tick();
    p0_addr = 16'h0009; p0_we = 1'b1;
    tick();
    n_checks++; if (mem_addr !== 16'h0003) $display("FAIL stable_mem_addr: got %h want 0003", mem_addr); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if (p0_done !== 1'b1 || p0_car_out !== 16'h789A || p0_header !== TYPE_NUMBER || p0_ptr !== 16'h0)
      $display("FAIL stable_result: got done %b car %h hdr %h ptr %h want 1 789a %h 0000", p0_done, p0_car_out, p0_header, p0_ptr, TYPE_NUMBER); else n_pass++;
    p0_req = 1'b0; p0_we = 1'b0;
    tick(); tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0005;
    repeat (6) tick();
    n_checks++; if (p0_done !== 1'b1 || p0_header !== 15'h0005)
      $display("FAIL wd_pre_read: got done %b hdr %h want 1 0005", p0_done, p0_header); else n_pass++;
    p0_req = 1'b0;
    tick(); tick();
    stall = 1'b1;
    p0_req = 1'b1; p0_addr = 16'h0003;
    repeat (17) tick();
    n_checks++; if (p0_done !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0)
      $display("FAIL wd_early: got done %b busy %b timeout %b want 0 1 0 after edge 17", p0_done, busy, timeout); else n_pass++;
    tick();
    n_checks++; if (p0_done !== 1'b1 || p0_err !== 1'b1 || timeout !== 1'b1)
      $display("FAIL wd_abort: got done %b err %b timeout %b want 1 1 1 after edge 18", p0_done, p0_err, timeout); else n_pass++;
    n_checks++; if (p0_header !== 15'h0005 || p0_car_out !== 16'h1005)
      $display("FAIL wd_read_kept: got %h %h want 0005 1005", p0_header, p0_car_out); else n_pass++;
    p0_req = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || p0_done !== 1'b0 || p0_err !== 1'b0)
      $display("FAIL wd_after: got busy %b done %b err %b want 0 0 0", busy, p0_done, p0_err); else n_pass++;
    stall = 1'b0;
    tick();
    p1_req = 1'b1; p1_we = 1'b1; p1_car = 16'h4321;
    repeat (5) tick();
    n_checks++; if (p1_done !== 1'b1 || p1_err !== 1'b0 || p1_ptr !== 16'h0006)
      $display("FAIL wd_pre_write: got done %b err %b ptr %h want 1 0 0006", p1_done, p1_err, p1_ptr); else n_pass++;
    p1_req = 1'b0;
    tick(); tick();
    stall = 1'b1;
    p1_req = 1'b1;
    repeat (18) tick();
    n_checks++; if (p1_done !== 1'b1 || p1_err !== 1'b1 || p1_ptr !== NIL_PTR)
      $display("FAIL wd_write_abort: got done %b err %b ptr %h want 1 1 %h", p1_done, p1_err, p1_ptr, NIL_PTR); else n_pass++;
    p1_req = 1'b0; stall = 1'b0;
    repeat (4) tick();
    n_checks++; if (timeout !== 1'b1) $display("FAIL wd_sticky: got %b want 1", timeout); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c0;
    do_reset();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0003;
    tick();
    stall = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0 || mem_addr !== 16'h0)
      $display("FAIL midreset_drop: got busy %b re %b we %b addr %h want 0 0 0 0000", busy, mem_read_enable, mem_write_enable, mem_addr); else n_pass++;
    p0_req = 1'b0; stall = 1'b0;
    c0 = cnt0;
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    n_checks++; if (cnt0 != c0 || busy !== 1'b0)
      $display("FAIL midreset_no_done: dones %0d busy %b want 0 0", cnt0 - c0, busy); else n_pass++;
    p0_req = 1'b1; p0_addr = 16'h0005;
    repeat (5) tick();
    n_checks++; if (p0_done !== 1'b0) $display("FAIL postreset_early: got %b want 0 after edge 5", p0_done); else n_pass++;
    tick();
    n_checks++; if (p0_done !== 1'b1 || p0_err !== 1'b0 || p0_car_out !== 16'h1005 || p0_cdr_out !== 16'h2005)
      $display("FAIL postreset_read: got done %b err %b car %h cdr %h want 1 0 1005 2005", p0_done, p0_err, p0_car_out, p0_cdr_out); else n_pass++;
    p0_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cnt0 = 0; cnt1 = 0;
    rst_n = 1'b0; stall = 1'b0; spur = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_type = 0; p0_car = 0; p0_cdr = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_type = 0; p1_car = 0; p1_cdr = 0;
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_addr_stable();
    test_watchdog();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
